// File: rtl/noc_cfg_pkg.sv
// Shared definitions for the NoC configuration packet loader:
// opcodes, flit field positions and the loader FSM state encoding.
package noc_cfg_pkg;

    localparam int unsigned FLIT_W   = 32;

    localparam logic [1:0]  OP_WRITE = 2'b01;
    localparam logic [1:0]  OP_READ  = 2'b10;
    localparam logic [1:0]  RSP_TAG  = 2'b10;

    // Header/response field positions; count and address widths follow ADDR_WIDTH.
    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 30;
    localparam int unsigned CNT_LSB  = 16;
    localparam int unsigned ADDR_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

endpackage

// File: rtl/cfg_rsp_register.sv
// Single-entry output holding register with valid/ready handshake.
// Accepts a new word when empty or when the current word drains this cycle.
module cfg_rsp_register #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_can_load
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_can_load;

    assign w_can_load = ~r_valid | i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load && w_can_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_can_load = w_can_load;

endmodule

// File: rtl/config_packet_loader.sv
// Decodes WRITE/READ command packets from a flit stream into register-file
// write strobes and read-response flits.
module config_packet_loader
    import noc_cfg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  Clock________i,
    input  logic                  Reset________i,
    input  logic [31:0]           Flit_data____i,
    input  logic                  Flit_valid___i,
    output logic                  Flit_ready___o,
    output logic                  Write_enable_o,
    output logic [ADDR_WIDTH-1:0] Write_addres_o,
    output logic [DATA_WIDTH-1:0] data_output__o,
    output logic [ADDR_WIDTH-1:0] Read_address_o,
    input  logic [DATA_WIDTH-1:0] Read_data____i,
    output logic [31:0]           Rsp_data_____o,
    output logic                  Rsp_valid____o,
    input  logic                  Rsp_ready____i,
    output logic                  Busy_________o,
    output logic                  Error_flag___o
);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_rem_nxt;
    logic                  w_we_nxt;
    logic                  w_wr_capture;
    logic                  w_err_set;
    logic                  w_rsp_load;
    logic                  w_rsp_can_load;
    logic                  w_flit_ready;
    logic                  w_flit_fire;
    logic [1:0]            w_opcode;
    logic [ADDR_WIDTH-1:0] w_hdr_count;
    logic [ADDR_WIDTH-1:0] w_hdr_addr;
    logic [DATA_WIDTH-1:0] w_payload;
    logic [FLIT_W-1:0]     w_rsp_word;
    logic                  w_unused_flit;

    assign w_flit_ready = (r_state != ST_READ);
    assign w_flit_fire  = Flit_valid___i & w_flit_ready;

    assign w_opcode    = Flit_data____i[OP_MSB:OP_LSB];
    assign w_hdr_count = Flit_data____i[CNT_LSB +: ADDR_WIDTH];
    assign w_hdr_addr  = Flit_data____i[ADDR_LSB +: ADDR_WIDTH];
    assign w_payload   = Flit_data____i[DATA_WIDTH-1:0];
    // Header/payload bits outside the decoded fields are don't-care.
    assign w_unused_flit = ^Flit_data____i;

    always_comb begin
        w_rsp_word = '0;
        w_rsp_word[OP_MSB:OP_LSB]          = RSP_TAG;
        w_rsp_word[CNT_LSB +: ADDR_WIDTH]  = r_addr_cnt;
        w_rsp_word[DATA_WIDTH-1:0]         = Read_data____i;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr_cnt;
        w_rem_nxt    = r_remaining;
        w_we_nxt     = 1'b0;
        w_wr_capture = 1'b0;
        w_err_set    = 1'b0;
        w_rsp_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_flit_fire) begin
                    case (w_opcode)
                        OP_WRITE: begin
                            w_addr_nxt  = w_hdr_addr;
                            w_rem_nxt   = w_hdr_count;
                            w_state_nxt = ST_WRITE;
                        end
                        OP_READ: begin
                            w_addr_nxt  = w_hdr_addr;
                            w_rem_nxt   = w_hdr_count;
                            w_state_nxt = ST_READ;
                        end
                        default: w_err_set = 1'b1;
                    endcase
                end
            end
            ST_WRITE: begin
                if (w_flit_fire) begin
                    w_we_nxt     = 1'b1;
                    w_wr_capture = 1'b1;
                    w_addr_nxt   = r_addr_cnt + ADDR_WIDTH'(1);
                    if (r_remaining == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_rem_nxt = r_remaining - ADDR_WIDTH'(1);
                    end
                end
            end
            ST_READ: begin
                // A word is issued whenever the response slot is free or draining.
                if (w_rsp_can_load) begin
                    w_rsp_load = 1'b1;
                    w_addr_nxt = r_addr_cnt + ADDR_WIDTH'(1);
                    if (r_remaining == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_rem_nxt = r_remaining - ADDR_WIDTH'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock________i) begin
        if (Reset________i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clock________i) begin
        if (Reset________i) begin
            r_addr_cnt  <= '0;
            r_remaining <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_addr_cnt  <= w_addr_nxt;
            r_remaining <= w_rem_nxt;
            r_we        <= w_we_nxt;
            if (w_wr_capture) begin
                r_waddr <= r_addr_cnt;
                r_wdata <= w_payload;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    cfg_rsp_register #(
        .WIDTH(FLIT_W)
    ) u_rsp (
        .i_clk      (Clock________i),
        .i_rst      (Reset________i),
        .i_load     (w_rsp_load),
        .i_data     (w_rsp_word),
        .i_ready    (Rsp_ready____i),
        .o_data     (Rsp_data_____o),
        .o_valid    (Rsp_valid____o),
        .o_can_load (w_rsp_can_load)
    );

    assign Flit_ready___o = w_flit_ready;
    assign Write_enable_o = r_we;
    assign Write_addres_o = r_waddr;
    assign data_output__o = r_wdata;
    assign Read_address_o = r_addr_cnt;
    assign Busy_________o = (r_state != ST_IDLE);
    assign Error_flag___o = r_err;

endmodule

// File: tb/tb_config_packet_loader.sv
// Directed bench for config_packet_loader with a behavioural register file
// attached to the write strobes and combinational read port.
module tb_config_packet_loader;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   flit;
    logic          flit_valid;
    logic          flit_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [31:0]   rsp_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          busy;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    config_packet_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .Clock________i (clk),
        .Reset________i (rst),
        .Flit_data____i (flit),
        .Flit_valid___i (flit_valid),
        .Flit_ready___o (flit_ready),
        .Write_enable_o (we),
        .Write_addres_o (waddr),
        .data_output__o (wdata),
        .Read_address_o (raddr),
        .Read_data____i (rdata),
        .Rsp_data_____o (rsp_data),
        .Rsp_valid____o (rsp_valid),
        .Rsp_ready____i (rsp_ready),
        .Busy_________o (busy),
        .Error_flag___o (err)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];

    typedef struct {
        logic [31:0]   flit;
        logic          valid;
        logic          exp_we;
        logic [AW-1:0] exp_waddr;
        logic [DW-1:0] exp_wdata;
        logic [AW-1:0] exp_raddr;
        logic          exp_busy;
        logic          exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_rsp [3];
        int got;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        //            flit          vld we waddr  wdata    raddr  busy err
        vecs[0]  = '{32'h4002_0005, 1, 0, 6'd0,  12'h000, 6'd5,  1, 0};
        vecs[1]  = '{32'h0000_0A11, 1, 1, 6'd5,  12'hA11, 6'd6,  1, 0};
        vecs[2]  = '{32'hFFFF_FB22, 1, 1, 6'd6,  12'hB22, 6'd7,  1, 0};
        vecs[3]  = '{32'h0000_0C33, 1, 1, 6'd7,  12'hC33, 6'd8,  0, 0};
        vecs[4]  = '{32'h0000_0000, 0, 0, 6'd7,  12'hC33, 6'd8,  0, 0};
        vecs[5]  = '{32'h4003_003E, 1, 0, 6'd7,  12'hC33, 6'd62, 1, 0};
        vecs[6]  = '{32'h0000_0001, 1, 1, 6'd62, 12'h001, 6'd63, 1, 0};
        vecs[7]  = '{32'h0000_0002, 1, 1, 6'd63, 12'h002, 6'd0,  1, 0};
        vecs[8]  = '{32'h0000_0003, 1, 1, 6'd0,  12'h003, 6'd1,  1, 0};
        vecs[9]  = '{32'h0000_0004, 1, 1, 6'd1,  12'h004, 6'd2,  0, 0};
        vecs[10] = '{32'hC000_0001, 1, 0, 6'd1,  12'h004, 6'd2,  0, 1};
        vecs[11] = '{32'h7FC0_FFC3, 1, 0, 6'd1,  12'h004, 6'd3,  1, 1};
        vecs[12] = '{32'h0000_0555, 1, 1, 6'd3,  12'h555, 6'd4,  0, 1};

        rst = 1'b1; flit = '0; flit_valid = 1'b0; rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_we",        32'(we),         32'd0);
        chk("rst_waddr",     32'(waddr),      32'd0);
        chk("rst_wdata",     32'(wdata),      32'd0);
        chk("rst_raddr",     32'(raddr),      32'd0);
        chk("rst_rsp_data",  rsp_data,        32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_err",       32'(err),        32'd0);
        chk("rst_ready",     32'(flit_ready), 32'd1);
        rst = 1'b0;

        // Write, wrap-write, illegal opcode and header-after-error vectors
        for (int i = 0; i < 13; i++) begin
            flit = vecs[i].flit;
            flit_valid = vecs[i].valid;
            tick();
            chk($sformatf("v%0d_we", i),    32'(we),        32'(vecs[i].exp_we));
            chk($sformatf("v%0d_waddr", i), 32'(waddr),     32'(vecs[i].exp_waddr));
            chk($sformatf("v%0d_wdata", i), 32'(wdata),     32'(vecs[i].exp_wdata));
            chk($sformatf("v%0d_raddr", i), 32'(raddr),     32'(vecs[i].exp_raddr));
            chk($sformatf("v%0d_busy", i),  32'(busy),      32'(vecs[i].exp_busy));
            chk($sformatf("v%0d_err", i),   32'(err),       32'(vecs[i].exp_err));
            chk($sformatf("v%0d_rdy", i),   32'(flit_ready), 32'd1);
            chk($sformatf("v%0d_rspv", i),  32'(rsp_valid), 32'd0);
        end
        flit_valid = 1'b0;
        tick();

        // Read-after-write, back to back
        flit = 32'h4000_0009; flit_valid = 1'b1; tick();
        flit = 32'h0000_0123; tick();
        chk("raw_we", 32'(we), 32'd1);
        flit = 32'h8000_0009; tick();
        flit_valid = 1'b0;
        chk("raw_ready", 32'(flit_ready), 32'd0);
        chk("raw_busy",  32'(busy),       32'd1);
        chk("raw_rspv0", 32'(rsp_valid),  32'd0);
        tick();
        chk("raw_rspv",  32'(rsp_valid),  32'd1);
        chk("raw_data",  rsp_data,        32'h8009_0123);
        chk("raw_idle",  32'(busy),       32'd0);
        rsp_ready = 1'b1; tick();
        chk("raw_drain", 32'(rsp_valid),  32'd0);
        rsp_ready = 1'b0;

        // Read with response backpressure
        exp_rsp[0] = 32'h8005_0A11;
        exp_rsp[1] = 32'h8006_0B22;
        exp_rsp[2] = 32'h8007_0C33;
        flit = 32'h8002_0005; flit_valid = 1'b1; tick();
        flit_valid = 1'b0;
        chk("bp_ready", 32'(flit_ready), 32'd0);
        tick();
        chk("bp_v0", 32'(rsp_valid), 32'd1);
        chk("bp_d0", rsp_data,       exp_rsp[0]);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_hold%0d_v", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_hold%0d_d", k), rsp_data,       exp_rsp[0]);
            chk($sformatf("bp_hold%0d_a", k), 32'(raddr),     32'd6);
            chk($sformatf("bp_hold%0d_b", k), 32'(busy),      32'd1);
        end
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got < 3; c++) begin
            if (rsp_valid) begin
                chk($sformatf("bp_word%0d", got), rsp_data, exp_rsp[got]);
                chk($sformatf("bp_seq%0d", got), 32'(c), 32'(got));
                got++;
            end
            tick();
        end
        chk("bp_count", 32'(got),       32'd3);
        chk("bp_end_v", 32'(rsp_valid), 32'd0);
        chk("bp_end_b", 32'(busy),      32'd0);
        rsp_ready = 1'b0;

        // Reset during a WRITE packet after one of three payloads
        flit = 32'h4002_0010; flit_valid = 1'b1; tick();
        flit = 32'h0000_00AA; tick();
        chk("rw_pulse1", 32'(we), 32'd1);
        rst = 1'b1; flit = 32'h0000_00BB; tick();
        chk("rw_we",    32'(we),         32'd0);
        chk("rw_waddr", 32'(waddr),      32'd0);
        chk("rw_wdata", 32'(wdata),      32'd0);
        chk("rw_raddr", 32'(raddr),      32'd0);
        chk("rw_busy",  32'(busy),       32'd0);
        chk("rw_err",   32'(err),        32'd0);
        chk("rw_rspv",  32'(rsp_valid),  32'd0);
        chk("rw_ready", 32'(flit_ready), 32'd1);
        rst = 1'b0;
        flit = 32'h4000_0014; tick();
        chk("rw_hdr_we",   32'(we),   32'd0);
        chk("rw_hdr_busy", 32'(busy), 32'd1);
        flit = 32'h0000_0777; tick();
        flit_valid = 1'b0;
        chk("rw_new_we",    32'(we),    32'd1);
        chk("rw_new_waddr", 32'(waddr), 32'd20);
        chk("rw_new_wdata", 32'(wdata), 32'h777);
        tick();
        chk("rw_new_end", 32'(we), 32'd0);

        // Pending response is dropped by reset
        flit = 32'h8000_0005; flit_valid = 1'b1; tick();
        flit_valid = 1'b0; tick();
        chk("rr_rspv", 32'(rsp_valid), 32'd1);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rr_drop",  32'(rsp_valid), 32'd0);
        chk("rr_data",  rsp_data,       32'd0);
        chk("rr_busy",  32'(busy),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
